// File: rtl/parking_gate_ctrl.sv
// parking_gate_ctrl
//   Single-lane parking gate controller. Entry and exit requests are latched
//   as pending flags. A round-robin arbiter picks one of them in IDLE. The gate
//   then opens for one cycle (OPEN), waits for the sensor or a timeout
//   (PASS_WAIT), and closes for one cycle (CLOSE). Free-slot counters change
//   only when a car actually clears the gate.
//
//   Parameters : REG_SLOTS (1..31), HC_SLOTS (1..31), GATE_CYCLES (2..255)
//   Build macro: HC_OVERFLOW_EN - if free_hc is 0, a handicapped entry may
//                use a regular slot.
//
//   Ports
//     clk, reset             clock, async active-high reset
//     entry_req, entry_hc    entry pulse + handicapped qualifier
//     exit_req, exit_hc      exit pulse + handicapped-slot qualifier
//     car_passed             gate sensor pulse
//     gate_open              gate drive
//     free_reg, free_hc      free slot counts
//     full_reg, full_hc      matching count is zero
//     reject, timeout        one-cycle event pulses
//     busy                   FSM not in IDLE
module parking_gate_ctrl #(
    parameter int REG_SLOTS   = 20,
    parameter int HC_SLOTS    = 5,
    parameter int GATE_CYCLES = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       entry_req,
    input  logic       entry_hc,
    input  logic       exit_req,
    input  logic       exit_hc,
    input  logic       car_passed,
    output logic       gate_open,
    output logic [4:0] free_reg,
    output logic [4:0] free_hc,
    output logic       full_reg,
    output logic       full_hc,
    output logic       reject,
    output logic       timeout,
    output logic       busy
);

    localparam logic [4:0] REG_MAX  = 5'(REG_SLOTS);
    localparam logic [4:0] HC_MAX   = 5'(HC_SLOTS);
    localparam logic [7:0] TMR_LOAD = 8'(GATE_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, OPEN, PASS_WAIT, CLOSE} state_t;

    state_t     state, state_nx;
    logic       ent_pend, ent_hc_q;
    logic       ext_pend, ext_hc_q;
    logic       rr_entry;    // 1: entry wins the next tie, 0: exit wins
    logic       cur_entry;   // transaction in flight is an entry
    logic       cur_hc;      // slot class the transaction affects
    logic [7:0] timer;

    logic       grant_exit, grant_entry;
    logic       ent_ok, ent_use_hc;

    // Arbitration only happens in IDLE.
    assign grant_exit  = (state == IDLE) && ext_pend && (!ent_pend || !rr_entry);
    assign grant_entry = (state == IDLE) && ent_pend && !grant_exit;

    // Slot selection for the pending entry. A regular car never takes an HC slot.
    always_comb begin
        ent_ok     = 1'b0;
        ent_use_hc = 1'b0;
        if (ent_hc_q) begin
            if (free_hc != 5'd0) begin
                ent_ok     = 1'b1;
                ent_use_hc = 1'b1;
            end
`ifdef HC_OVERFLOW_EN
            else if (free_reg != 5'd0) begin
                ent_ok = 1'b1;
            end
`endif
        end else begin
            ent_ok = (free_reg != 5'd0);
        end
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    // Next-state logic
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:      if (grant_exit || (grant_entry && ent_ok)) state_nx = OPEN;
            OPEN:      state_nx = PASS_WAIT;
            PASS_WAIT: if (car_passed || timer == 8'd0) state_nx = CLOSE;
            CLOSE:     state_nx = IDLE;
            default:   state_nx = IDLE;
        endcase
    end

    // Outputs decoded from state. Reset forces IDLE, so the gate drops at once.
    always_comb begin
        gate_open = (state == OPEN) || (state == PASS_WAIT);
        busy      = (state != IDLE);
    end

    assign full_reg = (free_reg == 5'd0);
    assign full_hc  = (free_hc == 5'd0);

    // Pending flags, arbiter pointer and transaction context
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ent_pend  <= 1'b0;
            ent_hc_q  <= 1'b0;
            ext_pend  <= 1'b0;
            ext_hc_q  <= 1'b0;
            rr_entry  <= 1'b0;
            cur_entry <= 1'b0;
            cur_hc    <= 1'b0;
        end else begin
            // A new pulse is only accepted while the flag is clear.
            if (grant_entry)               ent_pend <= 1'b0;
            else if (entry_req && !ent_pend) begin
                ent_pend <= 1'b1;
                ent_hc_q <= entry_hc;
            end
            if (grant_exit)                ext_pend <= 1'b0;
            else if (exit_req && !ext_pend) begin
                ext_pend <= 1'b1;
                ext_hc_q <= exit_hc;
            end

            if (grant_exit) begin
                rr_entry  <= 1'b1;
                cur_entry <= 1'b0;
                cur_hc    <= ext_hc_q;
            end else if (grant_entry) begin
                rr_entry  <= 1'b0;
                cur_entry <= 1'b1;
                cur_hc    <= ent_use_hc;
            end
        end
    end

    // Gate timer, slot counters and event pulses
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            timer    <= 8'd0;
            free_reg <= REG_MAX;
            free_hc  <= HC_MAX;
            reject   <= 1'b0;
            timeout  <= 1'b0;
        end else begin
            reject  <= grant_entry && !ent_ok;
            timeout <= (state == PASS_WAIT) && !car_passed && (timer == 8'd0);

            if (state == OPEN)
                timer <= TMR_LOAD;
            else if (state == PASS_WAIT && timer != 8'd0)
                timer <= timer - 8'd1;

            // Counters move only when the car really clears the gate.
            if (state == PASS_WAIT && car_passed) begin
                if (cur_entry) begin
                    if (cur_hc) begin
                        if (free_hc != 5'd0) free_hc <= free_hc - 5'd1;
                    end else begin
                        if (free_reg != 5'd0) free_reg <= free_reg - 5'd1;
                    end
                end else begin
                    if (cur_hc) begin
                        if (free_hc < HC_MAX) free_hc <= free_hc + 5'd1;
                    end else begin
                        if (free_reg < REG_MAX) free_reg <= free_reg + 5'd1;
                    end
                end
            end
        end
    end

endmodule

// File: doc/parking_gate_ctrl.md
PARKING_GATE_CTRL -- requirements
Module: parking_gate_ctrl

Interface
REQ-001 The module SHALL have parameter REG_SLOTS, default 20: number of regular slots (1..31).
REQ-002 The module SHALL have parameter HC_SLOTS, default 5: number of handicapped slots (1..31).
REQ-003 The module SHALL have parameter GATE_CYCLES, default 8: maximum cycles the gate stays open waiting for a car (2..255).
REQ-004 The module SHALL have port clk, input, 1: clock; all state updates on its rising edge.
REQ-005 The module SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-006 The module SHALL have port entry_req, input, 1: one-cycle pulse, car requests entry.
REQ-007 The module SHALL have port entry_hc, input, 1: qualifies entry_req; 1 = handicapped driver.
REQ-008 The module SHALL have port exit_req, input, 1: one-cycle pulse, car requests exit.
REQ-009 The module SHALL have port exit_hc, input, 1: qualifies exit_req; 1 = car leaving a handicapped slot.
REQ-010 The module SHALL have port car_passed, input, 1: pulse from the gate sensor, car has cleared the gate.
REQ-011 The module SHALL have port gate_open, output, 1: gate drive, 1 = open.
REQ-012 The module SHALL have port free_reg, output, 5: free regular slots.
REQ-013 The module SHALL have port free_hc, output, 5: free handicapped slots.
REQ-014 The module SHALL have ports full_reg and full_hc, outputs, 1 each: the matching free count is 0.
REQ-015 The module SHALL have port reject, output, 1: one-cycle pulse, entry refused because no slot is available.
REQ-016 The module SHALL have port timeout, output, 1: one-cycle pulse, gate closed without car_passed.
REQ-017 The module SHALL have port busy, output, 1: 1 whenever the state is not IDLE.

Function
REQ-018 Each entry_req/exit_req pulse SHALL set a pending flag that latches its class bit; a pulse arriving while that flag is already set SHALL be ignored.
REQ-019 The FSM SHALL have exactly four states: IDLE, OPEN, PASS_WAIT and CLOSE.
REQ-020 In IDLE with both flags pending, the grant SHALL alternate round-robin, starting with exit after reset; with one flag pending, that flag SHALL be granted.
REQ-021 A granted exit SHALL clear its pending flag and move to OPEN on the next edge.
REQ-022 A granted entry with an available slot SHALL reserve the class, clear its pending flag and move to OPEN on the next edge.
REQ-023 A granted entry with no available slot SHALL pulse reject for one cycle, clear its pending flag and remain in IDLE.
REQ-024 OPEN SHALL last one cycle with gate_open=1, load the timer with GATE_CYCLES-1 and then go to PASS_WAIT.
REQ-025 PASS_WAIT SHALL hold gate_open=1 and decrement the timer each cycle.
REQ-026 On car_passed in PASS_WAIT, the reserved counter SHALL update on that edge (entry: minus 1; exit: plus 1, saturating at REG_SLOTS/HC_SLOTS) and the FSM SHALL go to CLOSE.
REQ-027 If the timer reaches 0 without car_passed, the FSM SHALL pulse timeout, leave the counters unchanged and go to CLOSE.
REQ-028 CLOSE SHALL last one cycle with gate_open=0 and then return to IDLE.
REQ-029 car_passed outside PASS_WAIT SHALL be ignored.
REQ-030 Counters SHALL never go below 0 or above their parameter value.
REQ-031 full_reg, full_hc and busy SHALL be combinational from the registered state.

Reset
REQ-032 While reset is high, the block SHALL hold free_reg=REG_SLOTS, free_hc=HC_SLOTS, state=IDLE, gate_open=0, reject=0, timeout=0, pending flags cleared and round-robin pointer at exit.
REQ-033 Reset asserted mid-operation, including with the gate open, SHALL close the gate immediately and discard the transaction in progress.

Configuration
REQ-034 With HC_OVERFLOW_EN defined, a handicapped entry SHALL take a regular slot when free_hc=0 and free_reg>0, and that car's entry SHALL decrement free_reg.
REQ-035 Without HC_OVERFLOW_EN, a handicapped entry with free_hc=0 SHALL be rejected regardless of free_reg.
REQ-036 Regular entries SHALL never use handicapped slots in either configuration.

Verification
REQ-037 Reset, then regular entry_req, then car_passed 3 cycles after gate_open rises -> free_reg 20->19, gate_open high for 4 cycles, busy low again after CLOSE.
REQ-038 Entry and exit pulses in the same cycle -> exit served first, entry served after CLOSE; both counters net unchanged.
REQ-039 Five handicapped entries completed, then a sixth -> with HC_OVERFLOW_EN: free_reg 20->19; without it: reject pulse, no gate_open.
REQ-040 Entry with no car_passed -> gate_open high for GATE_CYCLES+1 cycles (OPEN plus the GATE_CYCLES-cycle wait), one timeout pulse, free_reg unchanged.
REQ-041 Exit at free_reg=20 -> gate opens and closes, free_reg stays 20.
REQ-042 Reset asserted in PASS_WAIT -> gate_open=0 in the same cycle, counters back to 20/5.
